bcd_to_binary_serial: RTL and testbench

- Multi-cycle converter from packed BCD digits to unsigned binary, using reverse double-dabble: shift right, then subtract 3 from any digit ≥ 8.
- It is the inverse of the display-path binary-to-BCD decoder.
- It sits on the operator-entry path: digits keyed in on switches/keys are converted to a 16-bit operand for the processor's data input or for an instruction-memory loader.
- Uses a ready/start request and a one-cycle valid result pulse.

---
 rtl/bcd_to_binary_serial_pkg.sv | 18 +
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/bcd_to_binary_serial.sv | 154 +++++++++++++++
 tb/tb_bcd_to_binary_serial.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_binary_serial_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_to_binary_serial_pkg;

  // Controller states; encodings are shared with the display-path decoder.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_ADJ       = 4'd3;
  localparam logic [3:0] BCD_ADJ_THR   = 4'd8;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a shifted digit >= 8 loses 3.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adjust
  import bcd_to_binary_serial_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // A digit that received a carried-down ten (8 after the shift) must read 5.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THR) begin
      digit_out = digit_in - BCD_ADJ;
    end
  end

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial packed-BCD to unsigned binary converter (reverse double-dabble).
// Latency: valid after edge 4*DIGITS+1 from accept (1 for invalid digits).
// Backpressure: start is honoured only while ready=1; no queuing.
// Build option: define BCD_SATURATE_EN to clamp overflowed results to all ones.
module bcd_to_binary_serial
  import bcd_to_binary_serial_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]  bcd_in,
  output logic                           ready,
  output logic                           valid,
  output logic [BIN_W-1:0]               binary_out,
  output logic                           overflow,
  output logic                           invalid
);

  // Accumulator is as wide as the BCD field, so the exact value fits before
  // truncation to BIN_W (BIN_W is expected to be <= 4*DIGITS).
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ACC_W - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_inv_q, pend_inv_d;
  logic [BIN_W-1:0]   binary_out_q, binary_out_d;
  logic               overflow_q, overflow_d;
  logic               invalid_q, invalid_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   bcd_shr;
  logic [ACC_W-1:0]   bcd_adj;
  logic [ACC_W-1:0]   acc_shr;
  logic               digit_bad;
  logic               acc_hi_nz;
  logic [BIN_W-1:0]   result_bin;

  // One shift step: {bcd, acc} >> 1, then per-digit correction of bcd.
  assign bcd_shr = bcd_q >> 1;
  assign acc_shr = {bcd_q[0], acc_q[ACC_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (bcd_shr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag any digit of the request that is not a decimal digit.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        digit_bad = 1'b1;
      end
    end
  end

  // Truncate the exact value to BIN_W, optionally clamping on overflow.
  always_comb begin
    acc_hi_nz = |(acc_q >> BIN_W);
`ifdef BCD_SATURATE_EN
    result_bin = acc_hi_nz ? {BIN_W{1'b1}} : acc_q[BIN_W-1:0];
`else
    result_bin = acc_q[BIN_W-1:0];
`endif
  end

  // Idle only once the result pulse has gone, so start never meets valid.
  assign ready      = (state_q == IDLE) && !valid_q;
  assign valid      = valid_q;
  assign binary_out = binary_out_q;
  assign overflow   = overflow_q;
  assign invalid    = invalid_q;

  // Next-state and datapath control for IDLE -> SHIFT -> DONE.
  always_comb begin
    state_d      = state_q;
    bcd_d        = bcd_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_inv_d   = pend_inv_q;
    binary_out_d = binary_out_q;
    overflow_d   = overflow_q;
    invalid_d    = invalid_q;
    valid_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && ready) begin
          bcd_d      = bcd_in;
          acc_d      = '0;
          cnt_d      = '0;
          pend_inv_d = digit_bad;
          state_d    = digit_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        acc_d = acc_shr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
        if (pend_inv_q) begin
          binary_out_d = '0;
          overflow_d   = 1'b0;
          invalid_d    = 1'b1;
        end else begin
          binary_out_d = result_bin;
          overflow_d   = acc_hi_nz;
          invalid_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bcd_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_inv_q   <= 1'b0;
      binary_out_q <= '0;
      overflow_q   <= 1'b0;
      invalid_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcd_q        <= bcd_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_inv_q   <= pend_inv_d;
      binary_out_q <= binary_out_d;
      overflow_q   <= overflow_d;
      invalid_q    <= invalid_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Directed bench for bcd_to_binary_serial with a result scoreboard.
// Expected values come from a decimal model of the packed BCD input.
// BCD_SATURATE_EN selects the clamped expectation for overflowed results.
module tb_bcd_to_binary_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] bcd_in;
  logic        ready;
  logic        valid;
  logic [15:0] binary_out;
  logic        overflow;
  logic        invalid;

  typedef struct {
    logic [15:0] bin;
    logic        ovf;
    logic        inv;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   compares = 0;
  int   fails    = 0;
  int   cyc      = 0;

  bcd_to_binary_serial #(.DIGITS(5), .BIN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bcd_in     (bcd_in),
    .ready      (ready),
    .valid      (valid),
    .binary_out (binary_out),
    .overflow   (overflow),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: value of the digits, invalid if any digit > 9.
  function automatic exp_t model(input logic [19:0] b);
    exp_t        e;
    int unsigned val;
    logic [3:0]  d;
    val   = 0;
    e.inv = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = b[i*4 +: 4];
      if (d > 4'd9) e.inv = 1'b1;
      val = val * 10 + int'(d);
    end
    e.ovf = !e.inv && (val > 65535);
    if (e.inv) e.bin = 16'h0000;
`ifdef BCD_SATURATE_EN
    else if (e.ovf) e.bin = 16'hFFFF;
`endif
    else e.bin = val[15:0];
    if (e.inv) e.ovf = 1'b0;
    e.lat     = e.inv ? 1 : 21;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Request one conversion; bcd_in is scrambled after the accepting edge.
  task automatic accept(input logic [19:0] b);
    exp_t e;
    @(negedge clk);
    check("ready_before_start", 32'(ready), 32'd1);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    e         = model(b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    start  = 1'b0;
    bcd_in = 20'($urandom);
    check("ready_busy", 32'(ready), 32'd0);
  endtask

  // Wait for the next valid pulse and compare it against the scoreboard head.
  task automatic wait_result(input int maxc);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (valid) got = 1'b1;
    end
    check("valid_seen", 32'(got), 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check("binary_out", 32'(binary_out), 32'(e.bin));
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("invalid", 32'(invalid), 32'(e.inv));
      check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      check("ready_during_valid", 32'(ready), 32'd0);
      @(negedge clk);
      check("ready_after_valid", 32'(ready), 32'd1);
      check("valid_one_cycle", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    int          extra;
    logic [15:0] held;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 20'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_binary_out", 32'(binary_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Main function and range boundaries.
    accept(20'h12345); wait_result(40);
    accept(20'h65535); wait_result(40);
    accept(20'h65536); wait_result(40);
    accept(20'h99999); wait_result(40);
    accept(20'h00000); wait_result(40);
    accept(20'h00009); wait_result(40);
    accept(20'h10000); wait_result(40);

    // Non-decimal digits take the short path.
    accept(20'h0A000); wait_result(40);
    accept(20'h9999F); wait_result(40);

    // Outputs hold between pulses.
    held = binary_out;
    repeat (5) @(negedge clk);
    check("hold_binary_out", 32'(binary_out), 32'(held));
    check("hold_invalid", 32'(invalid), 32'd1);

    // A second start while busy is dropped, not queued.
    accept(20'h00042);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h00007;
    @(negedge clk);
    start  = 1'b0;
    wait_result(40);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) extra++;
    end
    check("no_second_result", 32'(extra), 32'd0);
    check("ignored_start_hold", 32'(binary_out), 32'h002A);

    // Reset mid-conversion aborts cleanly.
    accept(20'h12345);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_binary_out", 32'(binary_out), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    accept(20'h00000); wait_result(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
